pid_param: RTL and testbench

Parametrised successor to the line-follower PID controller. Takes the signed line-position error stream from the IR sensing front end and produces unsigned left/right motor speed commands for the motor drive. It generalises the datapath widths and adds:
- runtime-programmable P/D gains,
- a saturating anti-windup integrator,
- a configurable-depth derivative history,
- a forward-speed ramp,
- a 3-stage pipeline with an output valid strobe.

---
 rtl/pid_pkg.sv | 45 ++++
 rtl/pid_integrator.sv | 38 +++
 rtl/pid_param.sv | 180 ++++++++++++++++++
 tb/tb_pid_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared defaults and saturation helpers for the parametrised line-follower PID controller.
package pid_pkg;

    localparam int ERR_W_DEF     = 16;
    localparam int SAT_W_DEF     = 10;
    localparam int I_W_DEF       = 16;
    localparam int I_SHIFT_DEF   = 4;
    localparam int D_DEPTH_DEF   = 2;
    localparam int D_W_DEF       = 8;
    localparam int SUM_W_DEF     = 14;
    localparam int OUT_SHIFT_DEF = 3;
    localparam int SPD_W_DEF     = 12;
    localparam int GAIN_W        = 6;

    localparam int unsigned FAST_SPD_DEF  = 32'h300;
    localparam int unsigned RAMP_STEP_DEF = 32'h010;

    // Clip a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v < 32'sd0) begin
            return '0;
        end
        if (v > hi) begin
            return $unsigned(hi);
        end
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/pid_integrator.sv
// Saturating signed accumulator: clr zeroes it (and beats en), en adds din with clipping.
module pid_integrator
    import pid_pkg::*;
#(
    parameter int I_W  = I_W_DEF,
    parameter int IN_W = SAT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [IN_W-1:0] din,
    output logic signed [I_W-1:0]  integ
);

    logic signed [I_W-1:0] integ_d;
    logic signed [I_W-1:0] integ_q;

    always_comb begin
        integ_d = integ_q;
        if (clr) begin
            integ_d = '0;
        end else if (en) begin
            integ_d = I_W'(sat_s(32'(integ_q) + 32'(din), I_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
        end else begin
            integ_q <= integ_d;
        end
    end

    assign integ = integ_q;

endmodule

// File: rtl/pid_param.sv
// Parametrised line-follower PID: error stream in, left/right motor speeds out through a
// 3-stage pipeline. out_vld is a one-cycle strobe marking fresh speeds; there is no backpressure.
module pid_param
    import pid_pkg::*;
#(
    parameter int          ERR_W     = ERR_W_DEF,
    parameter int          SAT_W     = SAT_W_DEF,
    parameter int          I_W       = I_W_DEF,
    parameter int          I_SHIFT   = I_SHIFT_DEF,
    parameter int          D_DEPTH   = D_DEPTH_DEF,
    parameter int          D_W       = D_W_DEF,
    parameter int          SUM_W     = SUM_W_DEF,
    parameter int          OUT_SHIFT = OUT_SHIFT_DEF,
    parameter int          SPD_W     = SPD_W_DEF,
    parameter int unsigned FAST_SPD  = FAST_SPD_DEF,
    parameter int unsigned RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic                    line_present,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [GAIN_W-1:0]       kp,
    input  logic [GAIN_W-1:0]       kd,
    output logic                    out_vld,
    output logic [SPD_W-1:0]        lft_spd,
    output logic [SPD_W-1:0]        rgt_spd
);

    localparam int P_W  = SAT_W + GAIN_W;
    localparam int DP_W = D_W + GAIN_W;

    logic                    line_present_q;
    logic                    clr;
    logic signed [SAT_W-1:0] err_sat;
    logic signed [SAT_W-1:0] hist_last;
    logic signed [D_W-1:0]   d_diff;
    logic signed [I_W-1:0]   integ;

    logic signed [SAT_W-1:0] hist_d [D_DEPTH];
    logic signed [SAT_W-1:0] hist_q [D_DEPTH];
    logic [SPD_W-1:0]        frwrd_d, frwrd_q;
    logic [SPD_W:0]          frwrd_inc;

    logic                    s1_vld_d, s1_vld_q;
    logic signed [SAT_W-1:0] s1_err_d, s1_err_q;
    logic signed [D_W-1:0]   s1_dd_d, s1_dd_q;

    logic                    s2_vld_d, s2_vld_q;
    logic signed [P_W-1:0]   s2_p_d, s2_p_q;
    logic signed [I_W-1:0]   s2_i_d, s2_i_q;
    logic signed [DP_W-1:0]  s2_d_d, s2_d_q;
    logic [SPD_W-1:0]        s2_frwrd_d, s2_frwrd_q;

    logic                    out_vld_d, out_vld_q;
    logic [SPD_W-1:0]        lft_spd_d, lft_spd_q;
    logic [SPD_W-1:0]        rgt_spd_d, rgt_spd_q;
    logic signed [31:0]      sum;
    logic signed [31:0]      steer;

    assign clr       = !go || (line_present && !line_present_q);
    assign err_sat   = SAT_W'(sat_s(32'(error), SAT_W));
    // A sample arriving with clr sees an empty history, matching the zeroed integrator and ramp.
    assign hist_last = clr ? '0 : hist_q[D_DEPTH-1];
    assign d_diff    = D_W'(sat_s(32'(err_sat) - 32'(hist_last), D_W));

    pid_integrator #(
        .I_W  (I_W),
        .IN_W (SAT_W)
    ) u_integ (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (err_vld),
        .din   (err_sat),
        .integ (integ)
    );

    always_comb begin
        for (int k = 0; k < D_DEPTH; k++) begin
            hist_d[k] = hist_q[k];
        end
        if (clr) begin
            for (int k = 0; k < D_DEPTH; k++) begin
                hist_d[k] = '0;
            end
        end else if (err_vld) begin
            hist_d[0] = err_sat;
            for (int k = 1; k < D_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    always_comb begin
        frwrd_inc = (SPD_W+1)'(frwrd_q) + (SPD_W+1)'(RAMP_STEP);
        frwrd_d   = frwrd_q;
        if (clr) begin
            frwrd_d = '0;
        end else if (err_vld) begin
            if (frwrd_inc > (SPD_W+1)'(FAST_SPD)) begin
                frwrd_d = SPD_W'(FAST_SPD);
            end else begin
                frwrd_d = frwrd_inc[SPD_W-1:0];
            end
        end
    end

    // S1 holds the sample; the integrator and ramp registers double as its integ/frwrd fields.
    always_comb begin
        s1_vld_d   = err_vld && go;
        s1_err_d   = err_sat;
        s1_dd_d    = d_diff;
        s2_vld_d   = s1_vld_q && go;
        s2_p_d     = P_W'(32'(s1_err_q) * $signed(32'(kp)));
        s2_i_d     = integ >>> I_SHIFT;
        s2_d_d     = DP_W'(32'(s1_dd_q) * $signed(32'(kd)));
        s2_frwrd_d = frwrd_q;
    end

    always_comb begin
        sum       = sat_s(32'(s2_p_q) + 32'(s2_i_q) + 32'(s2_d_q), SUM_W);
        steer     = sum >>> OUT_SHIFT;
        out_vld_d = 1'b0;
        lft_spd_d = lft_spd_q;
        rgt_spd_d = rgt_spd_q;
        if (!go) begin
            lft_spd_d = '0;
            rgt_spd_d = '0;
        end else if (s2_vld_q) begin
            out_vld_d = 1'b1;
            lft_spd_d = SPD_W'(clamp_u($signed(32'(s2_frwrd_q)) + steer, SPD_W));
            rgt_spd_d = SPD_W'(clamp_u($signed(32'(s2_frwrd_q)) - steer, SPD_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_present_q <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            frwrd_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_err_q   <= '0;
            s1_dd_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_p_q     <= '0;
            s2_i_q     <= '0;
            s2_d_q     <= '0;
            s2_frwrd_q <= '0;
            out_vld_q  <= 1'b0;
            lft_spd_q  <= '0;
            rgt_spd_q  <= '0;
        end else begin
            line_present_q <= line_present;
            for (int k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= hist_d[k];
            end
            frwrd_q    <= frwrd_d;
            s1_vld_q   <= s1_vld_d;
            s1_err_q   <= s1_err_d;
            s1_dd_q    <= s1_dd_d;
            s2_vld_q   <= s2_vld_d;
            s2_p_q     <= s2_p_d;
            s2_i_q     <= s2_i_d;
            s2_d_q     <= s2_d_d;
            s2_frwrd_q <= s2_frwrd_d;
            out_vld_q  <= out_vld_d;
            lft_spd_q  <= lft_spd_d;
            rgt_spd_q  <= rgt_spd_d;
        end
    end

    assign out_vld = out_vld_q;
    assign lft_spd = lft_spd_q;
    assign rgt_spd = rgt_spd_q;

endmodule

// File: tb/tb_pid_param.sv
// Bench for pid_param: a sample-level behavioural model with an expected-output queue,
// a per-cycle compare process, and directed scenarios pinned by hand-computed speeds.
module tb_pid_param;

    localparam int DDEP = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               go = 1'b0;
    logic               line_present = 1'b0;
    logic               err_vld = 1'b0;
    logic signed [15:0] error = '0;
    logic [5:0]         kp = 6'd16;
    logic [5:0]         kd = 6'd4;
    logic               out_vld;
    logic [11:0]        lft_spd;
    logic [11:0]        rgt_spd;

    int n_checks = 0;
    int n_fail   = 0;

    pid_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .line_present (line_present),
        .err_vld      (err_vld),
        .error        (error),
        .kp           (kp),
        .kd           (kd),
        .out_vld      (out_vld),
        .lft_spd      (lft_spd),
        .rgt_spd      (rgt_spd)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int es;
        int integ;
        int dd;
        int fw;
    } smp_t;

    smp_t        acc_q[$];
    logic [23:0] exp_q[$];
    int          m_hist[$] = '{0, 0};
    int          m_integ = 0;
    int          m_fw = 0;
    logic        lp_prev = 1'b0;
    logic        m_vld = 1'b0;
    logic [11:0] m_lft = '0;
    logic [11:0] m_rgt = '0;

    function automatic int sat_i(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int clamp_spd(input int v);
        return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
    endfunction

    always @(posedge clk) begin : model
        int          es;
        int          dd;
        int          sum;
        int          steer;
        logic        clr;
        smp_t        s;
        logic [23:0] e;
        if (!rst_n) begin
            acc_q.delete();
            exp_q.delete();
            m_hist  = '{0, 0};
            m_integ = 0;
            m_fw    = 0;
            lp_prev = 1'b0;
            m_vld   = 1'b0;
            m_lft   = '0;
            m_rgt   = '0;
        end else begin
            clr     = !go || (line_present && !lp_prev);
            lp_prev = line_present;
            es      = sat_i(int'(error), 10);
            if (!go) begin
                acc_q.delete();
                exp_q.delete();
                m_vld = 1'b0;
                m_lft = '0;
                m_rgt = '0;
            end else begin
                m_vld = 1'b0;
                if (exp_q.size() != 0) begin
                    e     = exp_q.pop_front();
                    m_lft = e[23:12];
                    m_rgt = e[11:0];
                    m_vld = 1'b1;
                end
                // Gains are applied one cycle after the sample is accepted.
                if (acc_q.size() != 0) begin
                    s     = acc_q.pop_front();
                    sum   = sat_i(s.es * int'(kp) + floor_div(s.integ, 16) + s.dd * int'(kd), 14);
                    steer = floor_div(sum, 8);
                    exp_q.push_back({12'(clamp_spd(s.fw + steer)), 12'(clamp_spd(s.fw - steer))});
                end
            end
            if (clr) begin
                m_integ = 0;
                m_hist  = '{0, 0};
                m_fw    = 0;
                if (err_vld && go) acc_q.push_back('{es, 0, sat_i(es, 8), 0});
            end else if (err_vld) begin
                m_integ = sat_i(m_integ + es, 16);
                dd      = sat_i(es - m_hist[DDEP-1], 8);
                m_hist.push_front(es);
                void'(m_hist.pop_back());
                m_fw    = (m_fw + 16 > 768) ? 768 : m_fw + 16;
                acc_q.push_back('{es, m_integ, dd, m_fw});
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("out_vld", 32'(out_vld), 32'(m_vld));
        check("lft_spd", 32'(lft_spd), 32'(m_lft));
        check("rgt_spd", 32'(rgt_spd), 32'(m_rgt));
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic g, input logic lp, input logic v, input logic signed [15:0] e);
        go           = g;
        line_present = lp;
        err_vld      = v;
        error        = e;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_vld", 32'(out_vld), 32'd0);
        check("async_rst_lft", 32'(lft_spd), 32'd0);
        check("async_rst_rgt", 32'(rgt_spd), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        rst_n = 1'b1;
    endtask

    task automatic expect_spd(input string name, input logic [11:0] l, input logic [11:0] r);
        check({name, "_lft"}, 32'(lft_spd), 32'(l));
        check({name, "_rgt"}, 32'(rgt_spd), 32'(r));
    endtask

    initial begin
        reset_dut();

        // Ramp with zero error.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'sd0);
            if (i == 2) begin
                check("first_vld", 32'(out_vld), 32'd1);
                expect_spd("ramp_first", 12'h010, 12'h010);
            end
        end
        expect_spd("ramp_top", 12'h300, 12'h300);

        // Step to +16 and run until the integrator pins.
        for (int i = 0; i < 2100; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'sd16);
            if (i == 2) expect_spd("step_first", 12'h328, 12'h2D8);
            if (i == 4) expect_spd("step_d_zero", 12'h320, 12'h2E0);
        end
        expect_spd("pos_integ_sat", 12'h41F, 12'h1E1);

        // Mid-run reset, then negative error.
        reset_dut();
        for (int i = 0; i < 2100; i++) begin
            drive(1'b1, 1'b0, 1'b1, -16'sd16);
            if (i == 2) expect_spd("neg_first", 12'h000, 12'h039);
        end
        expect_spd("neg_integ_sat", 12'h1E0, 12'h420);
        repeat (50) drive(1'b1, 1'b0, 1'b1, -16'sd16);
        expect_spd("neg_no_wrap", 12'h1E0, 12'h420);

        // Error saturation and sum saturation.
        reset_dut();
        repeat (60) drive(1'b1, 1'b0, 1'b1, 16'sh0300);
        expect_spd("sum_sat", 12'h6FF, 12'h000);

        // line_present rising edge with a sample in the same cycle.
        repeat (10) drive(1'b1, 1'b0, 1'b1, 16'sd16);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'sd16);
            if (i == 2) expect_spd("lp_clr_sample", 12'h028, 12'h000);
            if (i == 3) expect_spd("lp_after_clr", 12'h038, 12'h000);
        end

        // Gain change while the sample sits in S1 must apply to it.
        repeat (4) drive(1'b1, 1'b1, 1'b0, 16'sd0);
        drive(1'b1, 1'b1, 1'b1, 16'sd16);
        kp = 6'd8;
        drive(1'b1, 1'b1, 1'b0, 16'sd0);
        drive(1'b1, 1'b1, 1'b0, 16'sd0);
        check("gain_vld", 32'(out_vld), 32'd1);
        expect_spd("gain_s2", 12'h070, 12'h050);
        kp = 6'd16;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 16'sd0);

        // go drops with samples in flight.
        drive(1'b1, 1'b1, 1'b1, 16'sd0);
        drive(1'b1, 1'b1, 1'b1, 16'sd0);
        drive(1'b0, 1'b1, 1'b1, 16'sd0);
        check("go_drop_vld", 32'(out_vld), 32'd0);
        expect_spd("go_drop", 12'h000, 12'h000);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'sd0);
            check("go_low_vld", 32'(out_vld), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'sd0);
            if (i == 2) expect_spd("go_restart", 12'h010, 12'h010);
        end
        repeat (4) drive(1'b1, 1'b1, 1'b0, 16'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
